// File: rtl/clut_cache_loader_if.sv
// clut_cache_loader_if
//   Groups the request, memory and cache-write signals of the CLUT cache loader.
//   Signal names keep their direction prefixes as seen from the loader:
//     i_loadReq/i_clutX/i_clutY/i_is8bpp/i_invalidate  request side (setup stage)
//     o_busy/o_ready                                   status back to the setup stage
//     o_memReq/o_memAddr, i_memAck/i_memValid/i_memData  VRAM read port
//     o_write/o_writeBlockIndex/o_colors               CLUT cache write port
//   Modports:
//     master : the loader itself
//     slave  : the environment (setup stage, VRAM arbiter, cache)
interface clut_cache_loader_if;
  logic         i_loadReq;
  logic [5:0]   i_clutX;
  logic [8:0]   i_clutY;
  logic         i_is8bpp;
  logic         i_invalidate;
  logic         o_busy;
  logic         o_ready;
  logic         o_memReq;
  logic [14:0]  o_memAddr;
  logic         i_memAck;
  logic         i_memValid;
  logic [255:0] i_memData;
  logic         o_write;
  logic [3:0]   o_writeBlockIndex;
  logic [255:0] o_colors;

  modport master (
    input  i_loadReq, i_clutX, i_clutY, i_is8bpp, i_invalidate,
    input  i_memAck, i_memValid, i_memData,
    output o_busy, o_ready, o_memReq, o_memAddr,
    output o_write, o_writeBlockIndex, o_colors
  );

  modport slave (
    output i_loadReq, i_clutX, i_clutY, i_is8bpp, i_invalidate,
    output i_memAck, i_memValid, i_memData,
    input  o_busy, o_ready, o_memReq, o_memAddr,
    input  o_write, o_writeBlockIndex, o_colors
  );
endinterface

// File: rtl/clut_cache_loader.sv
// clut_cache_loader
//   Fills the 16 x 256-bit CLUT cache (16 colours per block) from VRAM.
//   Tracks the resident palette (tag X/Y + 8bpp flag); on a miss it fetches
//   only the missing 32-byte blocks over a req/ack/valid port and writes each
//   block into the cache, then reports o_ready.
//   Ports:
//     i_clk  clock
//     i_rst  asynchronous reset, active high
//     bus    clut_cache_loader_if.master (request, status, memory, cache write)
//     o_hitCnt/o_missCnt  saturating hit/miss counters, only when the macro
//                         CLUT_LOADER_PERF_EN is defined
//   All outputs are registered.
module clut_cache_loader #(
  parameter int NBLK = 16  // blocks in the cache; index width is fixed at 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  clut_cache_loader_if.master        bus
`ifdef CLUT_LOADER_PERF_EN
  ,
  output logic [15:0]                o_hitCnt,
  output logic [15:0]                o_missCnt
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, WRITE} stateT;

  stateT        stateReg, stateNext;
  logic [3:0]   blkReg, blkNext;
  logic [3:0]   lastReg, lastNext;
  logic [5:0]   xReg, xNext;
  logic [8:0]   yReg, yNext;
  logic         modeReg, modeNext;
  logic         tagValidReg, tagValidNext;
  logic         tag8bppReg, tag8bppNext;
  logic [5:0]   tagXReg, tagXNext;
  logic [8:0]   tagYReg, tagYNext;
  logic         restartReg, restartNext;
  logic         busyReg, busyNext;
  logic         readyReg, readyNext;
  logic         memReqReg, memReqNext;
  logic [14:0]  memAddrReg, memAddrNext;
  logic         writeReg, writeNext;
  logic [3:0]   idxReg, idxNext;
  logic [255:0] colorsReg, colorsNext;

  // An invalidate in the same cycle as a load request wins, so the tag is
  // treated as already dropped when deciding hit/miss and the start block.
  logic       tagValidEff;
  logic       xyMatch;
  logic       isHit;
  logic       upgrade;
  logic [3:0] startBlk;
  logic       restartNow;

  assign tagValidEff = tagValidReg && !bus.i_invalidate;
  assign xyMatch     = (tagXReg == bus.i_clutX) && (tagYReg == bus.i_clutY);
  assign isHit       = tagValidEff && xyMatch && (!bus.i_is8bpp || tag8bppReg);
  // 4bpp palette at the same X/Y already holds block 0 of the 8bpp palette.
  assign upgrade     = bus.i_is8bpp && tagValidEff && !tag8bppReg && xyMatch;
  assign startBlk    = upgrade ? 4'd1 : 4'd0;
  // Invalidate arriving in the WRITE cycle itself must also force a restart.
  assign restartNow  = restartReg || bus.i_invalidate;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      stateReg    <= IDLE;
      blkReg      <= 4'd0;
      lastReg     <= 4'd0;
      xReg        <= 6'd0;
      yReg        <= 9'd0;
      modeReg     <= 1'b0;
      tagValidReg <= 1'b0;
      tag8bppReg  <= 1'b0;
      tagXReg     <= 6'd0;
      tagYReg     <= 9'd0;
      restartReg  <= 1'b0;
      busyReg     <= 1'b0;
      readyReg    <= 1'b0;
      memReqReg   <= 1'b0;
      memAddrReg  <= 15'd0;
      writeReg    <= 1'b0;
      idxReg      <= 4'd0;
      colorsReg   <= 256'd0;
    end else begin
      stateReg    <= stateNext;
      blkReg      <= blkNext;
      lastReg     <= lastNext;
      xReg        <= xNext;
      yReg        <= yNext;
      modeReg     <= modeNext;
      tagValidReg <= tagValidNext;
      tag8bppReg  <= tag8bppNext;
      tagXReg     <= tagXNext;
      tagYReg     <= tagYNext;
      restartReg  <= restartNext;
      busyReg     <= busyNext;
      readyReg    <= readyNext;
      memReqReg   <= memReqNext;
      memAddrReg  <= memAddrNext;
      writeReg    <= writeNext;
      idxReg      <= idxNext;
      colorsReg   <= colorsNext;
    end
  end

  always_comb begin
    stateNext    = stateReg;
    blkNext      = blkReg;
    lastNext     = lastReg;
    xNext        = xReg;
    yNext        = yReg;
    modeNext     = modeReg;
    tagValidNext = tagValidReg;
    tag8bppNext  = tag8bppReg;
    tagXNext     = tagXReg;
    tagYNext     = tagYReg;
    restartNext  = restartReg;
    busyNext     = busyReg;
    readyNext    = readyReg;
    memReqNext   = 1'b0;
    memAddrNext  = memAddrReg;
    writeNext    = 1'b0;
    idxNext      = idxReg;
    colorsNext   = colorsReg;

    if (bus.i_invalidate && (stateReg != IDLE)) begin
      restartNext = 1'b1;
    end

    case (stateReg)
      IDLE: begin
        if (bus.i_invalidate) begin
          tagValidNext = 1'b0;
          readyNext    = 1'b0;
        end
        if (bus.i_loadReq) begin
          if (isHit) begin
            readyNext = 1'b1;
          end else begin
            xNext        = bus.i_clutX;
            yNext        = bus.i_clutY;
            modeNext     = bus.i_is8bpp;
            blkNext      = startBlk;
            lastNext     = bus.i_is8bpp ? 4'(NBLK - 1) : 4'd0;
            // Cache contents are about to be overwritten; the tag comes back
            // only once the whole palette is resident.
            tagValidNext = 1'b0;
            restartNext  = 1'b0;
            busyNext     = 1'b1;
            readyNext    = 1'b0;
            memReqNext   = 1'b1;
            memAddrNext  = {bus.i_clutY, bus.i_clutX + 6'(startBlk)};
            stateNext    = REQ;
          end
        end
      end

      REQ: begin
        memReqNext = 1'b1;
        if (bus.i_memAck) begin
          memReqNext = 1'b0;
          stateNext  = WAIT;
        end
      end

      WAIT: begin
        if (bus.i_memValid) begin
          colorsNext = bus.i_memData;
          idxNext    = blkReg;
          writeNext  = 1'b1;
          stateNext  = WRITE;
        end
      end

      WRITE: begin
        if (restartNow) begin
          // VRAM under the palette changed mid-load: refetch everything.
          restartNext = 1'b0;
          blkNext     = 4'd0;
          memReqNext  = 1'b1;
          memAddrNext = {yReg, xReg};
          stateNext   = REQ;
        end else if (blkReg == lastReg) begin
          tagValidNext = 1'b1;
          tag8bppNext  = modeReg;
          tagXNext     = xReg;
          tagYNext     = yReg;
          busyNext     = 1'b0;
          readyNext    = 1'b1;
          stateNext    = IDLE;
        end else begin
          blkNext     = blkReg + 4'd1;
          memReqNext  = 1'b1;
          // X wraps inside the VRAM line; Y is never carried into.
          memAddrNext = {yReg, xReg + 6'(blkReg + 4'd1)};
          stateNext   = REQ;
        end
      end

      default: stateNext = IDLE;
    endcase
  end

  assign bus.o_busy            = busyReg;
  assign bus.o_ready           = readyReg;
  assign bus.o_memReq          = memReqReg;
  assign bus.o_memAddr         = memAddrReg;
  assign bus.o_write           = writeReg;
  assign bus.o_writeBlockIndex = idxReg;
  assign bus.o_colors          = colorsReg;

`ifdef CLUT_LOADER_PERF_EN
  logic        hitAccept;
  logic        missAccept;
  logic [15:0] hitCntReg;
  logic [15:0] missCntReg;

  assign hitAccept  = (stateReg == IDLE) && bus.i_loadReq && isHit;
  assign missAccept = (stateReg == IDLE) && bus.i_loadReq && !isHit;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hitCntReg  <= 16'd0;
      missCntReg <= 16'd0;
    end else begin
      if (hitAccept && (hitCntReg != 16'hFFFF)) begin
        hitCntReg <= hitCntReg + 16'd1;
      end
      if (missAccept && (missCntReg != 16'hFFFF)) begin
        missCntReg <= missCntReg + 16'd1;
      end
    end
  end

  assign o_hitCnt  = hitCntReg;
  assign o_missCnt = missCntReg;
`endif

endmodule
